// File: rtl/unum4_mult_arb_if.sv
// Requester-side bus of unum4_mult_arb: per-requester operand handshake and result return.
// Slice i of every packed vector belongs to requester i.
interface unum4_mult_arb_if #(
  parameter int N_REQ     = 2,
  parameter int MAN_MAX_W = 29,
  parameter int EXP_MAX_W = 16,
  parameter int EXTRA     = 0
);
  localparam int RES_W = MAN_MAX_W + EXTRA;

  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ-1:0]           req_ready;
  logic [N_REQ*MAN_MAX_W-1:0] req_m_a;
  logic [N_REQ*MAN_MAX_W-1:0] req_m_b;
  logic [N_REQ*EXP_MAX_W-1:0] req_e_a;
  logic [N_REQ*EXP_MAX_W-1:0] req_e_b;

  logic [N_REQ-1:0]           res_valid;
  logic [N_REQ-1:0]           res_ready;
  logic [N_REQ*RES_W-1:0]     res_m;
  logic [N_REQ*EXP_MAX_W-1:0] res_e;
  logic [N_REQ-1:0]           res_over;
  logic [N_REQ-1:0]           res_under;

  // Front-ends side.
  modport master (
    output req_valid, req_m_a, req_m_b, req_e_a, req_e_b, res_ready,
    input  req_ready, res_valid, res_m, res_e, res_over, res_under
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_m_a, req_m_b, req_e_a, req_e_b, res_ready,
    output req_ready, res_valid, res_m, res_e, res_over, res_under
  );
endinterface

// File: rtl/unum4_mult_arb.sv
// Round-robin arbiter/sequencer sharing one pipelined unum4 multiplier among N_REQ requesters.
// Define UNUM4_MULT_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module unum4_mult_arb #(
  parameter int N_REQ     = 2,
  parameter int MAN_MAX_W = 29,
  parameter int EXP_MAX_W = 16,
  parameter int EXTRA     = 0,
  parameter int MULT_LAT  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  unum4_mult_arb_if.slave              bus,
  output logic                         mul_start,
  output logic [MAN_MAX_W-1:0]         mul_m_a,
  output logic [MAN_MAX_W-1:0]         mul_m_b,
  output logic [EXP_MAX_W-1:0]         mul_e_a,
  output logic [EXP_MAX_W-1:0]         mul_e_b,
  input  logic                         mul_done,
  input  logic [MAN_MAX_W+EXTRA-1:0]   mul_m_o,
  input  logic [EXP_MAX_W-1:0]         mul_e_o,
  input  logic                         mul_over,
  input  logic                         mul_under,
  output logic                         err
);
  localparam int RES_W = MAN_MAX_W + EXTRA;
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DEPTH = MULT_LAT + 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef logic [IDX_W-1:0] idx_t;

  logic [N_REQ-1:0] busy;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] res_hs;
  logic             accept;
  idx_t             grant_idx;

  // Per-requester views of the packed bus.
  logic [MAN_MAX_W-1:0] op_m_a [N_REQ];
  logic [MAN_MAX_W-1:0] op_m_b [N_REQ];
  logic [EXP_MAX_W-1:0] op_e_a [N_REQ];
  logic [EXP_MAX_W-1:0] op_e_b [N_REQ];

  logic [RES_W-1:0]     slot_m [N_REQ];
  logic [EXP_MAX_W-1:0] slot_e [N_REQ];
  logic [N_REQ-1:0]     slot_over;
  logic [N_REQ-1:0]     slot_under;
  logic [N_REQ-1:0]     slot_valid;

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign op_m_a[g] = bus.req_m_a[g*MAN_MAX_W +: MAN_MAX_W];
    assign op_m_b[g] = bus.req_m_b[g*MAN_MAX_W +: MAN_MAX_W];
    assign op_e_a[g] = bus.req_e_a[g*EXP_MAX_W +: EXP_MAX_W];
    assign op_e_b[g] = bus.req_e_b[g*EXP_MAX_W +: EXP_MAX_W];
    assign bus.res_m[g*RES_W +: RES_W]         = slot_m[g];
    assign bus.res_e[g*EXP_MAX_W +: EXP_MAX_W] = slot_e[g];
  end

  assign bus.res_valid = slot_valid;
  assign bus.res_over  = slot_over;
  assign bus.res_under = slot_under;
  assign bus.req_ready = grant;

  assign res_hs = slot_valid & bus.res_ready;
  // Nothing is granted while in reset so every output reads 0 during rst.
  assign elig   = bus.req_valid & ~busy & {N_REQ{~rst}};

  // ---------------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------------
`ifdef UNUM4_MULT_ARB_FIXED_PRIO_EN
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the loop can leave one unassigned and infer a latch.
    grant     = '0;
    grant_idx = '0;
    accept    = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!accept && elig[k]) begin
        grant[k]  = 1'b1;
        grant_idx = idx_t'(k);
        accept    = 1'b1;
      end
    end
  end
`else
  idx_t ptr;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the loop can leave one unassigned and infer a latch.
    grant     = '0;
    grant_idx = '0;
    accept    = 1'b0;
    // Offset k walks ptr+1, ptr+2, ... so the last winner is visited last.
    for (int k = 1; k <= N_REQ; k++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!accept && elig[j] && (j == (int'(ptr) + k) % N_REQ)) begin
          grant[j]  = 1'b1;
          grant_idx = idx_t'(j);
          accept    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments and test rst inside
    // the clocked block, giving a synchronous reset with no race between flops.
    if (rst) begin
      ptr <= idx_t'(N_REQ - 1);
    end else if (accept) begin
      ptr <= grant_idx;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Busy tracking and operand issue
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      // Set and clear never hit the same bit: a busy requester is never granted.
      busy <= (busy | grant) & ~res_hs;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_start <= 1'b0;
      mul_m_a   <= '0;
      mul_m_b   <= '0;
      mul_e_a   <= '0;
      mul_e_b   <= '0;
    end else begin
      mul_start <= accept;
      if (accept) begin
        mul_m_a <= op_m_a[grant_idx];
        mul_m_b <= op_m_b[grant_idx];
        mul_e_a <= op_e_a[grant_idx];
        mul_e_b <= op_e_b[grant_idx];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // In-order tag FIFO: which requester owns each operation in the multiplier
  // ---------------------------------------------------------------------------
  idx_t          tag_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          empty;
  idx_t          head;

  assign push  = accept;
  assign empty = (count == '0);
  assign pop   = mul_done & ~empty;
  assign head  = tag_mem[rd_ptr];

  // NOTE: the tag storage has no reset; wr_ptr, rd_ptr and count alone decide
  // which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // A done strobe with nothing outstanding is a multiplier protocol violation.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (mul_done && empty) begin
      err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Result slots, one per requester
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        slot_m[i] <= '0;
        slot_e[i] <= '0;
      end
      slot_over  <= '0;
      slot_under <= '0;
      slot_valid <= '0;
    end else begin
      slot_valid <= slot_valid & ~res_hs;
      // The head's slot is always empty here: its owner is still busy.
      if (pop) begin
        slot_m[head]     <= mul_m_o;
        slot_e[head]     <= mul_e_o;
        slot_over[head]  <= mul_over;
        slot_under[head] <= mul_under;
        slot_valid[head] <= 1'b1;
      end
    end
  end

  // Occupancy is bounded by one operation per requester and one issue per cycle.
  a_tag_no_overflow : assert property (
    @(posedge clk) disable iff (rst) !(push && !pop && count == CW'(DEPTH))
  );

endmodule

// File: tb/tb_unum4_mult_arb.sv
// Self-checking bench for unum4_mult_arb: a stand-in pipelined multiplier feeds
// per-requester scoreboards; scenario tasks check timing, arbitration and errors.
module tb_unum4_mult_arb;
  localparam int N_REQ    = 4;
  localparam int MAN_W    = 29;
  localparam int EXP_W    = 16;
  localparam int EXTRA    = 0;
  localparam int MULT_LAT = 4;
  localparam int RES_W    = MAN_W + EXTRA;

  typedef struct packed {
    logic [RES_W-1:0] m;
    logic [EXP_W-1:0] e;
    logic             over;
    logic             under;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  unum4_mult_arb_if #(
    .N_REQ(N_REQ), .MAN_MAX_W(MAN_W), .EXP_MAX_W(EXP_W), .EXTRA(EXTRA)
  ) bus ();

  logic             mul_start;
  logic [MAN_W-1:0] mul_m_a, mul_m_b;
  logic [EXP_W-1:0] mul_e_a, mul_e_b;
  logic             mul_done;
  logic [RES_W-1:0] mul_m_o;
  logic [EXP_W-1:0] mul_e_o;
  logic             mul_over, mul_under;
  logic             err;
  logic             spurious_done;

  unum4_mult_arb #(
    .N_REQ(N_REQ), .MAN_MAX_W(MAN_W), .EXP_MAX_W(EXP_W), .EXTRA(EXTRA), .MULT_LAT(MULT_LAT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mul_start(mul_start), .mul_m_a(mul_m_a), .mul_m_b(mul_m_b),
    .mul_e_a(mul_e_a), .mul_e_b(mul_e_b), .mul_done(mul_done),
    .mul_m_o(mul_m_o), .mul_e_o(mul_e_o), .mul_over(mul_over),
    .mul_under(mul_under), .err(err)
  );

  // Fixed-point product with the binary point below the sign bit; flags are
  // deliberately asymmetric in a/b so operand swaps are visible.
  function automatic res_t mul_model(input logic [MAN_W-1:0] ma, input logic [MAN_W-1:0] mb,
                                     input logic [EXP_W-1:0] ea, input logic [EXP_W-1:0] eb);
    res_t   r;
    longint p;
    p       = longint'($signed(ma)) * longint'($signed(mb));
    r.m     = RES_W'(p >>> (MAN_W - 1));
    r.e     = ea + eb;
    r.over  = ma[0];
    r.under = eb[0];
    return r;
  endfunction

  // Stand-in multiplier: fixed MULT_LAT start-to-done pipeline, reset with rst.
  res_t                pipe_d [MULT_LAT];
  logic [MULT_LAT-1:0] pipe_v;
  always @(posedge clk) begin
    if (rst) pipe_v <= '0;
    else     pipe_v <= {pipe_v[MULT_LAT-2:0], mul_start};
    pipe_d[0] <= mul_model(mul_m_a, mul_m_b, mul_e_a, mul_e_b);
    for (int s = 1; s < MULT_LAT; s++) pipe_d[s] <= pipe_d[s-1];
  end
  assign mul_done  = pipe_v[MULT_LAT-1] | spurious_done;
  assign mul_m_o   = pipe_d[MULT_LAT-1].m;
  assign mul_e_o   = pipe_d[MULT_LAT-1].e;
  assign mul_over  = pipe_d[MULT_LAT-1].over;
  assign mul_under = pipe_d[MULT_LAT-1].under;

  int   n_cmp = 0;
  int   n_mis = 0;
  res_t sb [N_REQ][$];

  logic [N_REQ-1:0]       obs_accept, obs_ready, obs_res_valid;
  logic                   obs_start, obs_err;
  logic [N_REQ*RES_W-1:0] obs_res_m;
  logic [N_REQ*EXP_W-1:0] obs_res_e;
  logic [MAN_W-1:0]       obs_mul_m_a;
  logic [EXP_W-1:0]       obs_mul_e_b;

  // One clock cycle: sample on the falling edge, run the scoreboard, then move
  // to just after the next rising edge where the caller drives new inputs.
  task automatic tick();
    res_t exp_r, got_r;
    @(negedge clk);
    obs_accept    = bus.req_valid & bus.req_ready;
    obs_ready     = bus.req_ready;
    obs_res_valid = bus.res_valid;
    obs_start     = mul_start;
    obs_err       = err;
    obs_res_m     = bus.res_m;
    obs_res_e     = bus.res_e;
    obs_mul_m_a   = mul_m_a;
    obs_mul_e_b   = mul_e_b;
    if (!rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i])
          sb[i].push_back(mul_model(bus.req_m_a[i*MAN_W +: MAN_W], bus.req_m_b[i*MAN_W +: MAN_W],
                                    bus.req_e_a[i*EXP_W +: EXP_W], bus.req_e_b[i*EXP_W +: EXP_W]));
        if (bus.res_valid[i] && bus.res_ready[i]) begin
          n_cmp++;
          if (sb[i].size() == 0) begin
            n_mis++;
            $display("FAIL sb_unexpected_%0d: result delivered with none outstanding", i);
          end else begin
            exp_r = sb[i].pop_front();
            got_r.m     = bus.res_m[i*RES_W +: RES_W];
            got_r.e     = bus.res_e[i*EXP_W +: EXP_W];
            got_r.over  = bus.res_over[i];
            got_r.under = bus.res_under[i];
            if (got_r !== exp_r) begin
              n_mis++;
              $display("FAIL sb_result_%0d: got m=%h e=%h o=%b u=%b, expected m=%h e=%h o=%b u=%b",
                       i, got_r.m, got_r.e, got_r.over, got_r.under,
                       exp_r.m, exp_r.e, exp_r.over, exp_r.under);
            end
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [MAN_W-1:0] ma, input logic [EXP_W-1:0] ea,
                         input logic [MAN_W-1:0] mb, input logic [EXP_W-1:0] eb);
    bus.req_m_a[i*MAN_W +: MAN_W] = ma;
    bus.req_e_a[i*EXP_W +: EXP_W] = ea;
    bus.req_m_b[i*MAN_W +: MAN_W] = mb;
    bus.req_e_b[i*EXP_W +: EXP_W] = eb;
  endtask

  task automatic flush_sb();
    for (int i = 0; i < N_REQ; i++) sb[i].delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.res_ready = '1;
    spurious_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    flush_sb();
  endtask

  task automatic drain(input string name);
    bus.req_valid = '0;
    bus.res_ready = '1;
    for (int c = 0; c < 12; c++) tick();
    for (int i = 0; i < N_REQ; i++) begin
      n_cmp++;
      if (sb[i].size() != 0) begin
        n_mis++;
        $display("FAIL %s_drain_%0d: %0d results outstanding, required 0", name, i, sb[i].size());
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '1;
    bus.res_ready = '1;
    spurious_done = 1'b0;
    for (int i = 0; i < N_REQ; i++) set_ops(i, '0, '0, '0, '0);
    tick();
    tick();
    n_cmp++;
    if (obs_ready !== '0 || obs_start !== 1'b0 || obs_res_valid !== '0 || obs_err !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_ctrl: ready=%b start=%b res_valid=%b err=%b, required all 0",
               obs_ready, obs_start, obs_res_valid, obs_err);
    end
    n_cmp++;
    if (obs_mul_m_a !== '0 || obs_res_m !== '0 || obs_res_e !== '0) begin
      n_mis++;
      $display("FAIL reset_data: mul_m_a=%h res_m=%h res_e=%h, required 0",
               obs_mul_m_a, obs_res_m, obs_res_e);
    end
    rst = 1'b0;
    bus.req_valid = '0;
    flush_sb();
  endtask

  task automatic test_single();
    logic [N_REQ-1:0] exp_rv;
    do_reset();
    set_ops(0, 29'h0800_0000, 16'd2, 29'h0800_0000, 16'd3);
    bus.req_valid = 4'b0001;
    tick();
    n_cmp++;
    if (obs_accept !== 4'b0001) begin
      n_mis++;
      $display("FAIL single_accept: got %b, required 0001", obs_accept);
    end
    bus.req_valid = '0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      n_cmp++;
      if (obs_start !== (c == 1)) begin
        n_mis++;
        $display("FAIL single_start_c%0d: got %b, required %b", c, obs_start, (c == 1));
      end
      exp_rv = (c == 6) ? 4'b0001 : 4'b0000;
      n_cmp++;
      if (obs_res_valid !== exp_rv) begin
        n_mis++;
        $display("FAIL single_res_valid_c%0d: got %b, required %b", c, obs_res_valid, exp_rv);
      end
      if (c == 1) begin
        n_cmp++;
        if (obs_mul_m_a !== 29'h0800_0000 || obs_mul_e_b !== 16'd3) begin
          n_mis++;
          $display("FAIL single_operands: mul_m_a=%h mul_e_b=%h, required 08000000 / 3",
                   obs_mul_m_a, obs_mul_e_b);
        end
      end
      if (c == 6) begin
        n_cmp++;
        if (obs_res_m[RES_W-1:0] !== 29'h0400_0000 || obs_res_e[EXP_W-1:0] !== 16'd5) begin
          n_mis++;
          $display("FAIL single_result: m=%h e=%0d, required 04000000 / 5",
                   obs_res_m[RES_W-1:0], obs_res_e[EXP_W-1:0]);
        end
      end
    end
    drain("single");
  endtask

  task automatic test_contention();
    logic [N_REQ-1:0] exp_acc [8] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000,
                                      4'b0000, 4'b0000, 4'b0000, 4'b0001};
    logic             exp_st  [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [N_REQ-1:0] exp_rv  [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                      4'b0000, 4'b0000, 4'b0001, 4'b0010};
    do_reset();
    set_ops(0, 29'h0C00_0000, 16'd1, 29'h0200_0001, 16'd4);
    set_ops(1, 29'h1F00_0000, 16'h0010, 29'h0A00_0000, 16'h0021);
    bus.req_valid = 4'b0011;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_cmp++;
      if (obs_accept !== exp_acc[c] || obs_start !== exp_st[c] || obs_res_valid !== exp_rv[c]) begin
        n_mis++;
        $display("FAIL contention_c%0d: accept=%b start=%b res_valid=%b, required %b %b %b",
                 c, obs_accept, obs_start, obs_res_valid, exp_acc[c], exp_st[c], exp_rv[c]);
      end
    end
    drain("contention");
  endtask

  task automatic test_fairness();
    int got [$];
    int exp_order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N_REQ; i++)
      set_ops(i, MAN_W'(32'h0100_0000 * (i + 1)), EXP_W'(i), MAN_W'(32'h0080_0003 + i),
              EXP_W'(16'h0100 + i));
    bus.req_valid = '1;
    for (int c = 0; c < 30 && got.size() < 5; c++) begin
      tick();
      if (obs_accept != '0) begin
        n_cmp++;
        if (!$onehot(obs_accept)) begin
          n_mis++;
          $display("FAIL fair_onehot_c%0d: accept=%b, required one-hot", c, obs_accept);
        end
        for (int i = 0; i < N_REQ; i++) if (obs_accept[i]) got.push_back(i);
      end
    end
    n_cmp++;
    if (got.size() < 5) begin
      n_mis++;
      $display("FAIL fair_timeout: %0d grants seen, required 5", got.size());
    end
    for (int k = 0; k < 5 && k < got.size(); k++) begin
      n_cmp++;
      if (got[k] != exp_order[k]) begin
        n_mis++;
        $display("FAIL fair_order_%0d: granted %0d, required %0d", k, got[k], exp_order[k]);
      end
    end
    drain("fair");
  endtask

  task automatic test_backpressure();
    do_reset();
    set_ops(0, 29'h1C00_0000, 16'h7FFF, 29'h0600_0001, 16'h0002);
    bus.req_valid = 4'b0001;
    bus.res_ready = 4'b1110;
    tick();
    n_cmp++;
    if (obs_accept !== 4'b0001) begin
      n_mis++;
      $display("FAIL bp_accept: got %b, required 0001", obs_accept);
    end
    for (int c = 1; c <= 15; c++) begin
      tick();
      n_cmp++;
      if (obs_ready[0] !== 1'b0 || obs_res_valid[0] !== (c >= 6)) begin
        n_mis++;
        $display("FAIL bp_hold_c%0d: ready0=%b res_valid0=%b, required 0 %b",
                 c, obs_ready[0], obs_res_valid[0], (c >= 6));
      end
    end
    bus.res_ready = '1;
    tick();
    n_cmp++;
    if (obs_res_valid[0] !== 1'b1 || obs_ready[0] !== 1'b0) begin
      n_mis++;
      $display("FAIL bp_handshake: res_valid0=%b ready0=%b, required 1 0",
               obs_res_valid[0], obs_ready[0]);
    end
    tick();
    n_cmp++;
    if (obs_accept !== 4'b0001) begin
      n_mis++;
      $display("FAIL bp_reaccept: got %b, required 0001", obs_accept);
    end
    drain("bp");
  endtask

  task automatic test_spurious();
    do_reset();
    spurious_done = 1'b1;
    tick();
    spurious_done = 1'b0;
    n_cmp++;
    if (obs_err !== 1'b0) begin
      n_mis++;
      $display("FAIL spur_err_early: got %b, required 0", obs_err);
    end
    for (int c = 1; c <= 5; c++) begin
      tick();
      n_cmp++;
      if (obs_err !== 1'b1 || obs_res_valid !== '0) begin
        n_mis++;
        $display("FAIL spur_c%0d: err=%b res_valid=%b, required 1 0000", c, obs_err, obs_res_valid);
      end
    end
    do_reset();
    tick();
    n_cmp++;
    if (obs_err !== 1'b0) begin
      n_mis++;
      $display("FAIL spur_err_cleared: got %b, required 0", obs_err);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    do_reset();
    set_ops(2, 29'h0300_0000, 16'd7, 29'h0500_0000, 16'd9);
    bus.req_valid = 4'b0100;
    tick();
    n_cmp++;
    if (obs_accept !== 4'b0100) begin
      n_mis++;
      $display("FAIL rmid_accept: got %b, required 0100", obs_accept);
    end
    bus.req_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    flush_sb();
    tick();
    n_cmp++;
    if (obs_start !== 1'b0 || obs_res_valid !== '0 || obs_err !== 1'b0 ||
        obs_mul_m_a !== '0 || obs_res_m !== '0 || obs_ready !== '0) begin
      n_mis++;
      $display("FAIL rmid_outputs: start=%b res_valid=%b err=%b mul_m_a=%h res_m=%h ready=%b, required 0",
               obs_start, obs_res_valid, obs_err, obs_mul_m_a, obs_res_m, obs_ready);
    end
    for (int c = 4; c <= 12; c++) begin
      tick();
      n_cmp++;
      if (obs_res_valid !== '0) begin
        n_mis++;
        $display("FAIL rmid_stray_c%0d: res_valid=%b, required 0000", c, obs_res_valid);
      end
    end
    bus.req_valid = 4'b0100;
    tick();
    n_cmp++;
    if (obs_accept !== 4'b0100) begin
      n_mis++;
      $display("FAIL rmid_new_accept: got %b, required 0100", obs_accept);
    end
    bus.req_valid = '0;
    lat = -1;
    for (int c = 1; c <= 12 && lat < 0; c++) begin
      tick();
      if (obs_res_valid[2]) lat = c;
    end
    n_cmp++;
    if (lat != 2 + MULT_LAT) begin
      n_mis++;
      $display("FAIL rmid_new_latency: got %0d, required %0d", lat, 2 + MULT_LAT);
    end
    drain("rmid");
  endtask

  initial begin
    rst           = 1'b1;
    spurious_done = 1'b0;
    bus.req_valid = '0;
    bus.res_ready = '1;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_backpressure();
    test_spurious();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
